// File: rtl/alu.sv
// 16-bit registered ALU: arithmetic, logic, shift and rotate ops.
// Ports: clk, rst_n (sync, active-low), c_in, a_in, b_in, alu_sel -> out, c_out.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_in,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic [3:0]  alu_sel,
  output logic [15:0] out,
  output logic        c_out
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOT   = 4'h5,
    OP_INC   = 4'h6,
    OP_DEC   = 4'h7,
    OP_SHL   = 4'h8,
    OP_SHR   = 4'h9,
    OP_ASR   = 4'hA,
    OP_RCL   = 4'hB,
    OP_RCR   = 4'hC,
    OP_NOR   = 4'hD,
    OP_PASSA = 4'hE,
    OP_PASSB = 4'hF
  } op_e;

  // res[16] is the next c_out, res[15:0] the next out
  logic [16:0] res;
  logic [16:0] a_ext;
  logic [16:0] cin_ext;

  assign a_ext   = {1'b0, a_in};
  assign cin_ext = {16'd0, c_in};

  always_comb begin
    res = '0;
    unique case (op_e'(alu_sel))
      OP_ADD:   res = a_ext + {1'b0, b_in} + cin_ext;
      OP_SUB:   res = a_ext + {1'b0, ~b_in} + cin_ext;
      OP_AND:   res = {1'b0, a_in & b_in};
      OP_OR:    res = {1'b0, a_in | b_in};
      OP_XOR:   res = {1'b0, a_in ^ b_in};
      OP_NOT:   res = {1'b0, ~a_in};
      OP_INC:   res = a_ext + 17'h00001;
      OP_DEC:   res = a_ext + 17'h0FFFF;
      OP_SHL:   res = {a_in[15], a_in[14:0], 1'b0};
      OP_SHR:   res = {a_in[0], 1'b0, a_in[15:1]};
      OP_ASR:   res = {a_in[0], a_in[15], a_in[15:1]};
      OP_RCL:   res = {a_in[15], a_in[14:0], c_in};
      OP_RCR:   res = {a_in[0], c_in, a_in[15:1]};
      OP_NOR:   res = {1'b0, ~(a_in | b_in)};
      OP_PASSA: res = {1'b0, a_in};
      OP_PASSB: res = {1'b0, b_in};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out   <= '0;
      c_out <= 1'b0;
    end else begin
      out   <= res[15:0];
      c_out <= res[16];
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset cases and
// randomized ops checked against an arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_in;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  alu_sel;
  logic [15:0] out;
  logic        c_out;

  int total = 0;
  int fails = 0;

  alu dut (
    .clk(clk),
    .rst_n(rst_n),
    .c_in(c_in),
    .a_in(a_in),
    .b_in(b_in),
    .alu_sel(alu_sel),
    .out(out),
    .c_out(c_out)
  );

  always #5 clk = ~clk;

  // returns {c_out, out}
  function automatic logic [16:0] model(int sel, int a, int b, int c);
    int r;
    int co;
    r  = 0;
    co = 0;
    case (sel)
      0:  begin r = a + b + c; co = r / 65536; end
      1:  begin r = a + (65535 - b) + c; co = r / 65536; end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 65535 - a;
      6:  begin r = a + 1; co = (a == 65535) ? 1 : 0; end
      7:  begin r = a + 65535; co = (a == 0) ? 0 : 1; end
      8:  begin r = a * 2; co = a / 32768; end
      9:  begin r = a / 2; co = a % 2; end
      10: begin r = a / 2 + (a / 32768) * 32768; co = a % 2; end
      11: begin r = a * 2 + c; co = a / 32768; end
      12: begin r = a / 2 + c * 32768; co = a % 2; end
      13: r = 65535 - (a | b);
      14: r = a;
      default: r = b;
    endcase
    r = r % 65536;
    return {co[0], r[15:0]};
  endfunction

  task automatic check(string tag, logic [16:0] exp);
    total++;
    assert ({c_out, out} === exp) else begin
      fails++;
      $error("FAIL %s: got c_out=%0b out=%h, expected c_out=%0b out=%h",
             tag, c_out, out, exp[16], exp[15:0]);
    end
  endtask

  task automatic drive(int sel, int a, int b, int c);
    alu_sel = sel[3:0];
    a_in    = a[15:0];
    b_in    = b[15:0];
    c_in    = c[0];
  endtask

  // apply one op, clock it, compare against model
  task automatic op(string tag, int sel, int a, int b, int c);
    logic [16:0] e;
    drive(sel, a, b, c);
    e = model(sel, a, b, c);
    @(posedge clk);
    #1;
    check(tag, e);
  endtask

  task automatic op_lit(string tag, int sel, int a, int b, int c,
                        logic [16:0] exp);
    drive(sel, a, b, c);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    int sel;
    int a;
    int b;
    int c;
    int pick;
    rst_n = 1'b0;
    drive(0, 16'hFFFF, 16'hFFFF, 1);
    @(posedge clk);
    #1;
    check("reset", 17'h00000);

    rst_n = 1'b1;
    op_lit("add_9_7_c1", 0, 16'h0009, 16'h0007, 1, {1'b0, 16'h0011});
    op_lit("sub_b_6", 1, 16'h000B, 16'h0006, 1, {1'b1, 16'h0005});
    op_lit("sub_6_b", 1, 16'h0006, 16'h000B, 1, {1'b0, 16'hFFFB});
    op_lit("add_d_5", 0, 16'h000D, 16'h0005, 0, {1'b0, 16'h0012});
    op_lit("add_max", 0, 16'hFFFF, 16'hFFFF, 1, {1'b1, 16'hFFFF});
    op_lit("inc_max", 6, 16'hFFFF, 16'h1234, 1, {1'b1, 16'h0000});
    op_lit("dec_zero", 7, 16'h0000, 16'h1234, 1, {1'b0, 16'hFFFF});
    op_lit("dec_one", 7, 16'h0001, 16'h0000, 0, {1'b1, 16'h0000});
    op_lit("rcl_8001", 11, 16'h8001, 16'h5555, 1, {1'b1, 16'h0003});
    op_lit("asr_8002", 10, 16'h8002, 16'h5555, 1, {1'b0, 16'hC001});
    op_lit("rcr_0001", 12, 16'h0001, 16'h0000, 1, {1'b1, 16'h8000});
    op_lit("shr_8001", 9, 16'h8001, 16'h0000, 1, {1'b1, 16'h4000});
    op_lit("shl_8001", 8, 16'h8001, 16'h0000, 1, {1'b1, 16'h0002});
    op_lit("nor", 13, 16'h00F0, 16'h0F00, 1, {1'b0, 16'hF00F});
    op_lit("passb", 15, 16'h1111, 16'hABCD, 1, {1'b0, 16'hABCD});

    op("b2b_add1", 0, 16'h1000, 16'h0234, 0);
    rst_n = 1'b0;
    drive(0, 16'h2000, 16'h0001, 1);
    @(posedge clk);
    #1;
    check("rst_mid", 17'h00000);
    rst_n = 1'b1;
    op("b2b_add2", 0, 16'h3000, 16'h0005, 1);

    for (int i = 0; i < 400; i++) begin
      sel  = int'($urandom_range(0, 15));
      pick = int'($urandom_range(0, 5));
      case (pick)
        0: a = 0;
        1: a = 65535;
        2: a = 32768;
        default: a = int'($urandom_range(0, 65535));
      endcase
      b = int'($urandom_range(0, 65535));
      c = int'($urandom_range(0, 1));
      op($sformatf("rand%0d_sel%0d", i, sel), sel, a, b, c);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
